// File: rtl/spi_byte_engine_if.sv
// Signal bundle between the ctrl-code decoder side and the SPI byte engine.
// The master modport drives requests and device lines; the slave modport is the engine.
interface spi_byte_engine_if #(
  parameter int DIVW = 4
);
  logic            start;
  logic [7:0]      txd;
  logic [DIVW-1:0] div;
  logic            cpol;
  logic [1:0]      nss;
  logic [2:0]      miso;
  logic            bb_sck;
  logic            bb_mosi;
  logic            sck;
  logic            mosi;
  logic            busy;
  logic            done;
  logic [7:0]      rxd;

  modport master (
    output start, txd, div, cpol, nss, miso, bb_sck, bb_mosi,
    input  sck, mosi, busy, done, rxd
  );

  modport slave (
    input  start, txd, div, cpol, nss, miso, bb_sck, bb_mosi,
    output sck, mosi, busy, done, rxd
  );
endinterface

// File: rtl/spi_byte_engine.sv
// CPHA=0 SPI byte shifter: one START shifts eight bits MSB first; when idle,
// SCK/MOSI pass the software bit-bang levels through with one cycle of latency.
module spi_byte_engine #(
  parameter int DIVW = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  spi_byte_engine_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  logic [1:0]      state_q,  state_d;
  logic [7:0]      shreg_q,  shreg_d;
  logic [7:0]      rxd_q,    rxd_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [DIVW-1:0] divcnt_q, divcnt_d;
  logic [DIVW-1:0] div_q,    div_d;
  logic            cpol_q,   cpol_d;
  logic            sck_q,    sck_d;
  logic            mosi_q,   mosi_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic            misox;

  // nSS=2'b11 (no software select) routes the third device line.
  assign misox = (bus.miso[0] & ~bus.nss[0]) |
                 (bus.miso[1] & ~bus.nss[1]) |
                 (bus.miso[2] &  bus.nss[0] & bus.nss[1]);

  always_comb begin
    // NOTE: every variable starts from its held value so no path leaves it unassigned (no latches).
    state_d  = state_q;
    shreg_d  = shreg_q;
    rxd_d    = rxd_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;
    div_d    = div_q;
    cpol_d   = cpol_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sck_d  = bus.bb_sck;
        mosi_d = bus.bb_mosi;
        if (bus.start) begin
          shreg_d  = bus.txd;
          bitcnt_d = 3'd7;
          divcnt_d = bus.div;
          div_d    = bus.div;
          cpol_d   = bus.cpol;
          sck_d    = bus.cpol;
          mosi_d   = bus.txd[7];
          busy_d   = 1'b1;
          state_d  = ST_LOW;
        end
      end

      ST_LOW: begin
        if (divcnt_q != '0) begin
          divcnt_d = divcnt_q - DIVW'(1);
        end else begin
          // Leading edge: sample the selected device line.
          sck_d    = ~cpol_q;
          shreg_d  = {shreg_q[6:0], misox};
          divcnt_d = div_q;
          state_d  = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (divcnt_q != '0) begin
          divcnt_d = divcnt_q - DIVW'(1);
        end else begin
          sck_d = cpol_q;
          if (bitcnt_q != 3'd0) begin
            bitcnt_d = bitcnt_q - 3'd1;
            mosi_d   = shreg_q[7];
            divcnt_d = div_q;
            state_d  = ST_LOW;
          end else begin
            rxd_d   = shreg_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      rxd_q    <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      div_q    <= '0;
      cpol_q   <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      rxd_q    <= rxd_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      div_q    <= div_d;
      cpol_q   <= cpol_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.rxd  = rxd_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Scoreboard bench for spi_byte_engine: a behavioural SPI slave feeds MISO,
// a monitor checks each completed byte against expectations queued at launch.
module tb_spi_byte_engine;
  localparam int DIVW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_byte_engine_if #(.DIVW(DIVW)) bus ();

  spi_byte_engine #(.DIVW(DIVW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [7:0]  rx;
    logic [7:0]  tx;
    int unsigned busy_len;
    logic        cpol;
    int unsigned gap;
  } exp_t;

  typedef struct {
    logic [7:0] pat;
    logic       cpol;
    logic [1:0] nss;
  } slv_t;

  exp_t        sb_q[$];
  slv_t        slv_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned done_cnt = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Behavioural SPI slave, CPHA=0: presents the MSB when selected, next bit after each trailing edge.
  logic [7:0] s_pat      = 8'h00;
  logic       s_cpol     = 1'b0;
  logic [1:0] s_nss      = 2'b11;
  int         s_idx      = 0;
  logic       s_bit      = 1'b0;
  logic       s_busy_prv = 1'b0;
  logic       s_sck_prv  = 1'b0;

  always @(negedge clk) begin
    logic [2:0] m;
    slv_t       s;
    if (!rst_n) begin
      s_busy_prv = 1'b0;
      s_sck_prv  = bus.sck;
    end else begin
      if (bus.busy && !s_busy_prv) begin
        if (slv_q.size() > 0) begin
          s      = slv_q.pop_front();
          s_pat  = s.pat;
          s_cpol = s.cpol;
          s_nss  = s.nss;
          s_idx  = 7;
          s_bit  = s_pat[7];
        end
      end else if (bus.busy && bus.sck != s_sck_prv && bus.sck == s_cpol && s_idx > 0) begin
        s_idx--;
        s_bit = s_pat[s_idx];
      end
      s_busy_prv = bus.busy;
      s_sck_prv  = bus.sck;
    end
    // Unselected lines carry noise; the selected one(s) carry the data bit.
    m = 3'($urandom());
    case (s_nss)
      2'b00:   begin m[0] = s_bit; m[1] = s_bit; end
      2'b01:   m[1] = s_bit;
      2'b10:   m[0] = s_bit;
      default: m[2] = s_bit;
    endcase
    bus.miso = m;
  end

  // Monitor: tracks BUSY length, leading edges and MOSI bits; compares on DONE.
  logic        m_busy_prv = 1'b0;
  logic        m_sck_prv  = 1'b0;
  int unsigned m_len      = 0;
  int unsigned m_lead     = 0;
  logic [7:0]  m_mosi     = 8'h00;
  int unsigned m_last     = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_busy_prv = 1'b0;
      m_sck_prv  = bus.sck;
      m_len      = 0;
      m_lead     = 0;
    end else begin
      if (bus.busy && !m_busy_prv) begin
        m_len  = 0;
        m_lead = 0;
        m_mosi = 8'h00;
      end
      if (bus.busy) begin
        m_len++;
        if (sb_q.size() > 0 && bus.sck != m_sck_prv && bus.sck == !sb_q[0].cpol) begin
          m_lead++;
          m_mosi = {m_mosi[6:0], bus.mosi};
        end
      end
      if (bus.done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          e = sb_q.pop_front();
          check("rxd", bus.rxd, e.rx);
          check("mosi_bits", m_mosi, e.tx);
          check("busy_len", m_len, e.busy_len);
          check("lead_edges", m_lead, 8);
          check("sck_at_done", bus.sck, e.cpol);
          check("busy_at_done", bus.busy, 1'b0);
          if (e.gap != 0) check("done_gap", cyc - m_last, e.gap);
        end
        m_last = cyc;
      end
      m_busy_prv = bus.busy;
      m_sck_prv  = bus.sck;
    end
  end

  function automatic exp_t mk_exp(input logic [7:0] tx, input logic [DIVW-1:0] dv,
                                  input logic cp, input logic [7:0] pat, input int unsigned gap);
    exp_t e;
    e.rx       = pat;
    e.tx       = tx;
    e.busy_len = 16 * (int'(dv) + 1);
    e.cpol     = cp;
    e.gap      = gap;
    return e;
  endfunction

  function automatic slv_t mk_slv(input logic [7:0] pat, input logic cp, input logic [1:0] ns);
    slv_t s;
    s.pat  = pat;
    s.cpol = cp;
    s.nss  = ns;
    return s;
  endfunction

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic launch(input logic [7:0] tx, input logic [DIVW-1:0] dv, input logic cp,
                        input logic [1:0] ns, input logic [7:0] pat);
    bus.txd    = tx;
    bus.div    = dv;
    bus.cpol   = cp;
    bus.nss    = ns;
    bus.bb_sck = cp;
    bus.start  = 1'b1;
    sb_q.push_back(mk_exp(tx, dv, cp, pat, 0));
    slv_q.push_back(mk_slv(pat, cp, ns));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) fail("busy_timeout");
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]      tx, pat, last_rx;
    logic [DIVW-1:0] dv;
    logic            cp, bs, bm, ps, pm;
    logic [1:0]      ns;
    int unsigned     d0;
    int              n;

    bus.start   = 1'b0;
    bus.txd     = 8'h00;
    bus.div     = '0;
    bus.cpol    = 1'b0;
    bus.nss     = 2'b11;
    bus.bb_sck  = 1'b0;
    bus.bb_mosi = 1'b0;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sck", bus.sck, 1'b0);
    check("rst_mosi", bus.mosi, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_rxd", bus.rxd, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Fastest clock, device 0 echoes the transmitted byte.
    launch(8'hA5, 4'd0, 1'b0, 2'b10, 8'hA5);
    wait_done(300);

    // DIV=3, CPOL=1, device 2 holds MISO high.
    launch(8'h3C, 4'd3, 1'b1, 2'b11, 8'hFF);
    wait_done(300);
    check("cpol1_idle_sck", bus.sck, 1'b1);

    // STARTs during BUSY are ignored.
    d0 = done_cnt;
    launch(8'h5A, 4'd0, 1'b0, 2'b10, 8'h81);
    repeat (4) @(negedge clk);
    bus.txd = 8'h3C; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.txd = 8'h3C; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    wait_done(300);
    repeat (3) @(negedge clk);
    check("ignored_start_dones", done_cnt - d0, 1);
    check("ignored_start_drain", sb_q.size(), 0);

    // START held across DONE: second byte accepted in the DONE cycle.
    d0 = done_cnt;
    bus.txd = 8'hC6; bus.div = 4'd0; bus.cpol = 1'b0; bus.nss = 2'b01; bus.bb_sck = 1'b0;
    bus.start = 1'b1;
    sb_q.push_back(mk_exp(8'hC6, 4'd0, 1'b0, 8'h5B, 0));
    sb_q.push_back(mk_exp(8'h27, 4'd0, 1'b0, 8'hE4, 17));
    slv_q.push_back(mk_slv(8'h5B, 1'b0, 2'b01));
    slv_q.push_back(mk_slv(8'hE4, 1'b0, 2'b01));
    @(negedge clk);
    bus.txd = 8'h27;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) fail("b2b_first_done_timeout");
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(300);
    repeat (2) @(negedge clk);
    check("b2b_dones", done_cnt - d0, 2);

    // Reset mid-transfer aborts with no DONE.
    d0 = done_cnt;
    launch(8'h96, 4'd0, 1'b0, 2'b10, 8'h69);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    slv_q.delete();
    @(negedge clk);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_sck", bus.sck, 1'b0);
    check("abort_mosi", bus.mosi, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_rxd", bus.rxd, 8'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_rxd_held", bus.rxd, 8'h00);
    launch(8'h4E, 4'd1, 1'b0, 2'b00, 8'hB2);
    wait_done(300);
    last_rx = 8'hB2;

    // Idle passthrough of the bit-bang levels.
    d0 = done_cnt;
    ps = bus.bb_sck;
    pm = bus.bb_mosi;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bs = 1'($urandom());
      bm = 1'($urandom());
      if (i == 0) begin bs = ~ps; bm = ~pm; end
      bus.bb_sck  = bs;
      bus.bb_mosi = bm;
      #1;
      check("bb_sck_hold", bus.sck, ps);
      check("bb_mosi_hold", bus.mosi, pm);
      @(negedge clk);
      check("bb_sck_follow", bus.sck, bs);
      check("bb_mosi_follow", bus.mosi, bm);
      ps = bs;
      pm = bm;
    end
    check("bb_rxd_kept", bus.rxd, last_rx);
    check("bb_no_done", done_cnt - d0, 0);

    // Randomized transfers with the live inputs scrambled after acceptance.
    for (int i = 0; i < 12; i++) begin
      tx  = 8'($urandom());
      pat = 8'($urandom());
      dv  = DIVW'($urandom_range(0, 6));
      cp  = 1'($urandom());
      ns  = 2'($urandom());
      bus.bb_sck = cp;
      @(negedge clk);
      launch(tx, dv, cp, ns, pat);
      bus.txd  = 8'($urandom());
      bus.div  = DIVW'($urandom());
      bus.cpol = 1'($urandom());
      wait_done(300);
    end

    repeat (3) @(negedge clk);
    check("final_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
